// File: rtl/branch_pc_unit_pkg.sv
// Shared processor definitions: datapath width, branch funct3 encodings,
// and the fetch redirect FSM states.
package branch_pc_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_pc_unit_br_cond_decode.sv
// Branch condition decode: maps funct3 and comparator flags to a taken bit
// and selects comparator signedness.
module br_cond_decode
  import branch_pc_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       taken,
  output logic       br_unsigned
);

  assign br_unsigned = funct3[1];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = equal;
      F3_BNE:           taken = ~equal;
      F3_BLT, F3_BLTU:  taken = less;
      F3_BGE, F3_BGEU:  taken = ~less;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register with branch/jump redirect and a post-redirect flush
// window that squashes younger pipeline slots.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic            br_less_i,
  input  logic            br_equal_i,
  input  logic [XLEN-1:0] target_i,
  output logic            br_unsigned_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            redirect_o,
  output logic            flush_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e          state, state_next;
  logic [2:0]      cnt, cnt_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            taken;
  logic            redirect;

  br_cond_decode u_cond (
    .funct3      (funct3_i),
    .less        (br_less_i),
    .equal       (br_equal_i),
    .taken       (taken),
    .br_unsigned (br_unsigned_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
      cnt   <= '0;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (!stall_i) begin
          if (cnt == '0) state_next = ST_RUN;
          else           cnt_next   = cnt - 3'd1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Jumps take precedence over branches; flush cycles never redirect.
  always_comb begin
    redirect = ~rst_i & (state == ST_RUN) & ~stall_i &
               (is_jal_i | is_jalr_i | (is_branch_i & taken));
    flush_o  = ~rst_i & (state == ST_FLUSH);
  end

  always_comb begin
    pc_next = pc + 32'd4;
    if (stall_i)       pc_next = pc;
    else if (redirect) pc_next = {target_i[XLEN-1:1], target_i[0] & ~is_jalr_i};
  end

  assign redirect_o = redirect;
  assign pc_o       = pc;
  assign pc_plus4_o = pc + 32'd4;

endmodule
